// File: rtl/nes_mem_arbiter.sv
// Slot-based arbiter feeding the SDRAM controller: loader FIFO writes, CPU reads/writes, PPU reads.
// Define ARB_ROUND_ROBIN_EN to alternate CPU/PPU on ties; otherwise the CPU always beats the PPU.
module nes_mem_arbiter #(
    parameter int ADDR_W      = 25,
    parameter int SLOT_CYCLES = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clkref,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_full,
    output logic              dl_overflow,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic [7:0]        cpu_dout,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_busy,
    output logic              ppu_ack,
    output logic [7:0]        ppu_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_din,
    output logic              mem_oeA,
    output logic              mem_oeB,
    input  logic [7:0]        mem_doutA,
    input  logic [7:0]        mem_doutB
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(SLOT_CYCLES - 2);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {GRANT_NONE, GRANT_LOADER, GRANT_CPU, GRANT_PPU} grant_e;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];

    logic              clkref_d_q;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              dl_full_q, dl_full_d, dl_overflow_q, dl_overflow_d;
    logic              cpu_busy_q, cpu_busy_d, cpu_we_q, cpu_we_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d, ppu_addr_q, ppu_addr_d;
    logic [7:0]        cpu_din_q, cpu_din_d;
    logic              ppu_busy_q, ppu_busy_d;
    logic              cpu_ack_q, cpu_ack_d, ppu_ack_q, ppu_ack_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d, ppu_dout_q, ppu_dout_d;
    grant_e            grant_q, grant_d;
    logic [CW-1:0]     slot_cnt_q, slot_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic              mem_we_q, mem_we_d, mem_oea_q, mem_oea_d, mem_oeb_q, mem_oeb_d;

    logic slot_start, push, pop, complete, pick_cpu;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the CPU owns the next CPU/PPU tie; reset 0 hands the first tie to the PPU.
    logic last_cpu_q, last_cpu_d;
    assign pick_cpu = ~ppu_busy_q | last_cpu_q;
`else
    assign pick_cpu = 1'b1;
`endif

    always_comb begin
        slot_start = clkref & ~clkref_d_q;
        push       = dl_wr & ~dl_full_q;
        pop        = slot_start & (count_q != '0);
        // A new slot edge wins over completion: the old grant is abandoned and stays pending.
        complete   = ~slot_start & (slot_cnt_q == CNT_DONE);

        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d       = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        dl_full_d     = (count_d == CNT_FULL);
        dl_overflow_d = dl_overflow_q | (dl_wr & dl_full_q);

        cpu_busy_d = cpu_busy_q;
        cpu_we_d   = cpu_we_q;
        cpu_addr_d = cpu_addr_q;
        cpu_din_d  = cpu_din_q;
        if (cpu_req && !cpu_busy_q) begin
            cpu_busy_d = 1'b1;
            cpu_we_d   = cpu_we;
            cpu_addr_d = cpu_addr;
            cpu_din_d  = cpu_din;
        end
        ppu_busy_d = ppu_busy_q;
        ppu_addr_d = ppu_addr_q;
        if (ppu_req && !ppu_busy_q) begin
            ppu_busy_d = 1'b1;
            ppu_addr_d = ppu_addr;
        end

        grant_d    = grant_q;
        slot_cnt_d = (slot_cnt_q == CNT_LAST) ? slot_cnt_q : slot_cnt_q + 1'b1;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_d   = mem_we_q;
        mem_oea_d  = mem_oea_q;
        mem_oeb_d  = mem_oeb_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_cpu_d = last_cpu_q;
`endif

        if (slot_start) begin
            slot_cnt_d = '0;
            mem_we_d   = 1'b0;
            mem_oea_d  = 1'b0;
            mem_oeb_d  = 1'b0;
            if (count_q != '0) begin
                grant_d    = GRANT_LOADER;
                mem_we_d   = 1'b1;
                mem_addr_d = fifo_addr[rd_ptr_q];
                mem_din_d  = fifo_data[rd_ptr_q];
            end else if (cpu_busy_q && pick_cpu) begin
                grant_d    = GRANT_CPU;
                mem_addr_d = cpu_addr_q;
                mem_we_d   = cpu_we_q;
                mem_oea_d  = ~cpu_we_q;
                if (cpu_we_q) mem_din_d = cpu_din_q;
`ifdef ARB_ROUND_ROBIN_EN
                last_cpu_d = 1'b0;
`endif
            end else if (ppu_busy_q) begin
                grant_d    = GRANT_PPU;
                mem_addr_d = ppu_addr_q;
                mem_oeb_d  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                last_cpu_d = 1'b1;
`endif
            end else begin
                grant_d = GRANT_NONE;
            end
        end

        cpu_ack_d  = complete & (grant_q == GRANT_CPU);
        ppu_ack_d  = complete & (grant_q == GRANT_PPU);
        cpu_dout_d = (cpu_ack_d && mem_oea_q) ? mem_doutA : cpu_dout_q;
        ppu_dout_d = ppu_ack_d ? mem_doutB : ppu_dout_q;
        if (cpu_ack_d) cpu_busy_d = 1'b0;
        if (ppu_ack_d) ppu_busy_d = 1'b0;
    end

    // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= dl_addr;
            fifo_data[wr_ptr_q] <= dl_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkref_d_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            dl_full_q     <= 1'b0;
            dl_overflow_q <= 1'b0;
            cpu_busy_q    <= 1'b0;
            cpu_we_q      <= 1'b0;
            cpu_addr_q    <= '0;
            cpu_din_q     <= '0;
            ppu_busy_q    <= 1'b0;
            ppu_addr_q    <= '0;
            cpu_ack_q     <= 1'b0;
            ppu_ack_q     <= 1'b0;
            cpu_dout_q    <= '0;
            ppu_dout_q    <= '0;
            grant_q       <= GRANT_NONE;
            slot_cnt_q    <= CNT_LAST;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_we_q      <= 1'b0;
            mem_oea_q     <= 1'b0;
            mem_oeb_q     <= 1'b0;
        end else begin
            clkref_d_q    <= clkref;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            dl_full_q     <= dl_full_d;
            dl_overflow_q <= dl_overflow_d;
            cpu_busy_q    <= cpu_busy_d;
            cpu_we_q      <= cpu_we_d;
            cpu_addr_q    <= cpu_addr_d;
            cpu_din_q     <= cpu_din_d;
            ppu_busy_q    <= ppu_busy_d;
            ppu_addr_q    <= ppu_addr_d;
            cpu_ack_q     <= cpu_ack_d;
            ppu_ack_q     <= ppu_ack_d;
            cpu_dout_q    <= cpu_dout_d;
            ppu_dout_q    <= ppu_dout_d;
            grant_q       <= grant_d;
            slot_cnt_q    <= slot_cnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_we_q      <= mem_we_d;
            mem_oea_q     <= mem_oea_d;
            mem_oeb_q     <= mem_oeb_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_cpu_q <= 1'b0;
        else       last_cpu_q <= last_cpu_d;
    end
`endif

    assign dl_full     = dl_full_q;
    assign dl_overflow = dl_overflow_q;
    assign cpu_busy    = cpu_busy_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_dout    = cpu_dout_q;
    assign ppu_busy    = ppu_busy_q;
    assign ppu_ack     = ppu_ack_q;
    assign ppu_dout    = ppu_dout_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_din     = mem_din_q;
    assign mem_oeA     = mem_oea_q;
    assign mem_oeB     = mem_oeb_q;
endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Randomized bench for nes_mem_arbiter; a slot-level reference model predicts each grant and completion.
module tb_nes_mem_arbiter;
    localparam int AW = 25;
    localparam int SC = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset, clkref, dl_wr, cpu_req, cpu_we, ppu_req;
    logic [AW-1:0] dl_addr, cpu_addr, ppu_addr;
    logic [7:0]    dl_data, cpu_din, stub_a, stub_b;
    logic          dl_full, dl_overflow, cpu_busy, cpu_ack, ppu_busy, ppu_ack;
    logic          mem_we, mem_oeA, mem_oeB;
    logic [7:0]    cpu_dout, ppu_dout, mem_din;
    logic [AW-1:0] mem_addr;

    nes_mem_arbiter #(.ADDR_W(AW), .SLOT_CYCLES(SC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .clkref(clkref),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_full(dl_full), .dl_overflow(dl_overflow),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr),
        .ppu_busy(ppu_busy), .ppu_ack(ppu_ack), .ppu_dout(ppu_dout),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
        .mem_oeA(mem_oeA), .mem_oeB(mem_oeB),
        .mem_doutA(stub_a), .mem_doutB(stub_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending requests, loader queue and what the memory bus last showed.
    typedef struct packed {logic [AW-1:0] a; logic [7:0] d;} dl_t;
    dl_t           fifo_m[$];
    bit            m_ovf, m_cpu_p, m_cpu_we, m_ppu_p, m_next_cpu;
    logic [AW-1:0] m_cpu_a, m_ppu_a, m_addr;
    logic [7:0]    m_cpu_d, m_din;

    task automatic model_reset();
        fifo_m.delete();
        m_ovf = 0; m_cpu_p = 0; m_cpu_we = 0; m_ppu_p = 0; m_next_cpu = 0;
        m_cpu_a = '0; m_ppu_a = '0; m_addr = '0; m_cpu_d = '0; m_din = '0;
    endtask

    function automatic bit tie_to_cpu();
`ifdef ARB_ROUND_ROBIN_EN
        return m_next_cpu;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [63:0] all_outputs();
        return {6'd0, dl_full, dl_overflow, cpu_busy, cpu_ack, cpu_dout, ppu_busy, ppu_ack,
                ppu_dout, mem_we, mem_oeA, mem_oeB, mem_addr, mem_din};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic dl_push(input logic [AW-1:0] a, input logic [7:0] d);
        dl_wr = 1; dl_addr = a; dl_data = d;
        if (fifo_m.size() < FD) fifo_m.push_back({a, d});
        else m_ovf = 1;
        tick();
        dl_wr = 0;
    endtask

    task automatic cpu_issue(input bit we, input logic [AW-1:0] a, input logic [7:0] d);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_din = d;
        if (!m_cpu_p) begin m_cpu_p = 1; m_cpu_we = we; m_cpu_a = a; m_cpu_d = d; end
        tick();
        cpu_req = 0;
    endtask

    task automatic ppu_issue(input logic [AW-1:0] a);
        ppu_req = 1; ppu_addr = a;
        if (!m_ppu_p) begin m_ppu_p = 1; m_ppu_a = a; end
        tick();
        ppu_req = 0;
    endtask

    // One slot: clkref rises now; optionally a CPU read is strobed in the slot-start cycle itself.
    task automatic run_slot(input bit late_cpu, input logic [AW-1:0] late_a,
                            input logic [7:0] sa, input logic [7:0] sb);
        int            g;
        bit            rd;
        dl_t           h;
        logic [35:0]   eb;
        logic [1:0]    eack;
        g = 0; rd = 0;
        if (fifo_m.size() != 0) begin
            g = 1; h = fifo_m.pop_front();
            m_addr = h.a; m_din = h.d; eb = {3'b100, m_addr, m_din};
        end else if (m_cpu_p && (!m_ppu_p || tie_to_cpu())) begin
            g = 2; rd = !m_cpu_we; m_addr = m_cpu_a; m_next_cpu = 0;
            if (m_cpu_we) begin m_din = m_cpu_d; eb = {3'b100, m_addr, m_din}; end
            else eb = {3'b010, m_addr, m_din};
        end else if (m_ppu_p) begin
            g = 3; m_addr = m_ppu_a; m_next_cpu = 1; eb = {3'b001, m_addr, m_din};
        end else begin
            eb = {3'b000, m_addr, m_din};
        end
        eack = (g == 2) ? 2'b10 : (g == 3) ? 2'b01 : 2'b00;

        stub_a = sa; stub_b = sb; clkref = 1;
        if (late_cpu) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = late_a; cpu_din = 8'h00;
            if (!m_cpu_p) begin m_cpu_p = 1; m_cpu_we = 0; m_cpu_a = late_a; m_cpu_d = 8'h00; end
        end
        tick();
        cpu_req = 0;
        for (int k = 0; k < SC + 4; k++) begin
            check("mem_bus", {28'd0, mem_we, mem_oeA, mem_oeB, mem_addr, mem_din}, {28'd0, eb});
            check("acks", {62'd0, cpu_ack, ppu_ack}, {62'd0, (k == SC - 1) ? eack : 2'b00});
            if (k == SC - 1 && g == 2 && rd) check("cpu_dout", {56'd0, cpu_dout}, {56'd0, sa});
            if (k == SC - 1 && g == 3)       check("ppu_dout", {56'd0, ppu_dout}, {56'd0, sb});
            if (g == 2 && k >= SC - 2 && k <= SC - 1) check("cpu_busy_fall", {63'd0, cpu_busy}, {63'd0, k == SC - 2});
            if (g == 3 && k >= SC - 2 && k <= SC - 1) check("ppu_busy_fall", {63'd0, ppu_busy}, {63'd0, k == SC - 2});
            if (k == 2) clkref = 0;
            tick();
        end
        if (g == 2) m_cpu_p = 0;
        if (g == 3) m_ppu_p = 0;
        check("flags", {60'd0, cpu_busy, ppu_busy, dl_full, dl_overflow},
              {60'd0, m_cpu_p, m_ppu_p, fifo_m.size() == FD, m_ovf});
    endtask

    initial begin
        reset = 1; clkref = 0; dl_wr = 0; cpu_req = 0; cpu_we = 0; ppu_req = 0;
        dl_addr = '0; dl_data = '0; cpu_addr = '0; cpu_din = '0; ppu_addr = '0;
        stub_a = '0; stub_b = '0;
        model_reset();
        #1 check("reset_outputs", all_outputs(), 64'd0);
        repeat (3) tick();
        reset = 0;
        tick();

        // CPU read, then CPU write.
        cpu_issue(0, 25'h0012345, 8'h00);
        run_slot(0, '0, 8'hA5, 8'h00);
        cpu_issue(1, 25'h0000010, 8'h3C);
        run_slot(0, '0, 8'h00, 8'h00);

        // Loader burst: fifth write overflows, then drain in order.
        for (int i = 0; i < 5; i++) begin
            dl_push(AW'(i), 8'h10 + 8'(i));
            if (i == 3) check("dl_full_after_4", {63'd0, dl_full}, 64'd1);
        end
        check("dl_overflow_after_5", {63'd0, dl_overflow}, 64'd1);
        for (int i = 0; i < 4; i++) run_slot(0, '0, 8'h00, 8'h00);

        // Priority: loader, then CPU/PPU tie, then the loser, then an empty slot.
        dl_push(25'h1ABCDE, 8'h77);
        cpu_issue(0, 25'h0000200, 8'h00);
        ppu_issue(25'h0000300);
        for (int i = 0; i < 4; i++) run_slot(0, '0, 8'h5A, 8'hC3);

        // A CPU request strobed in the slot-start cycle waits for the next slot.
        run_slot(1, 25'h0000400, 8'h11, 8'h22);
        run_slot(0, '0, 8'h33, 8'h44);

        // Asynchronous reset in the middle of a PPU read.
        ppu_issue(25'h0000500);
        clkref = 1;
        repeat (3) tick();
        clkref = 0;
        repeat (4) tick();
        #2 reset = 1;
        #1 check("reset_mid_slot", all_outputs(), 64'd0);
        tick();
        reset = 0;
        model_reset();
        for (int i = 0; i < SC + 2; i++) begin
            check("no_ack_after_reset", {61'd0, ppu_ack, cpu_ack, ppu_busy}, 64'd0);
            tick();
        end
        ppu_issue(25'h0000600);
        run_slot(0, '0, 8'h00, 8'h9E);

        // Random traffic.
        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) dl_push(AW'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) cpu_issue(1'($urandom), AW'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) ppu_issue(AW'($urandom));
            run_slot($urandom_range(0, 3) == 0, AW'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
